// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: state type, round-count constants, controller FSM
// encoding and the round-constant / rotate helpers used by the round function.
package ascon_pkg;

   localparam int ROUNDS_PA   = 12;
   localparam int ROUNDS_PB   = 6;
   localparam int ROUNDS_P8   = 8;
   localparam int ROUND_CNT_W = 4;

   // Word 0 is x0, word 4 is x4.
   typedef logic [4:0][63:0] ascon_state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } perm_state_e;

   // round_cnt counts down from 12, so round index i = 12 - rc and the
   // constant ((15-i)<<4)|i becomes {rc+3, 12-rc}.
   function automatic logic [7:0] round_const(input logic [ROUND_CNT_W-1:0] rc);
      return {4'(rc + 4'd3), 4'(4'd12 - rc)};
   endfunction

   function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
      return (v >> n) | (v << (64 - n));
   endfunction

endpackage

// File: rtl/ascon_perm_ctrl_if.sv
// Handshake and state bus between the mode controller (master) and the
// Ascon permutation driver (slave).
interface ascon_perm_ctrl_if;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [3:0]  rounds_i;
   logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
   logic        busy_o;

   modport slave (
      input  in_valid_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
      output in_ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o, busy_o
   );

   modport master (
      output in_valid_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
      input  in_ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o, busy_o
   );
endinterface

// File: rtl/asconp.sv
// Combinational single Ascon-p round: constant addition, 5-bit S-box layer
// and per-word linear diffusion.
module asconp
   import ascon_pkg::*;
(
   input  logic [ROUND_CNT_W-1:0] round_cnt,
   input  ascon_state_t           x_i,
   output ascon_state_t           x_o
);

   ascon_state_t s;
   ascon_state_t t;

   // One full round, bitsliced S-box followed by the linear layer
   always_comb begin
      s    = x_i;
      s[2] = s[2] ^ {56'd0, round_const(round_cnt)};
      s[0] = s[0] ^ s[4];
      s[4] = s[4] ^ s[3];
      s[2] = s[2] ^ s[1];
      for (int i = 0; i < 5; i++) begin
         t[i] = ~s[i] & s[(i + 1) % 5];
      end
      for (int i = 0; i < 5; i++) begin
         s[i] = s[i] ^ t[(i + 1) % 5];
      end
      s[1] = s[1] ^ s[0];
      s[0] = s[0] ^ s[4];
      s[3] = s[3] ^ s[2];
      s[2] = ~s[2];
      x_o[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
      x_o[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
      x_o[2] = s[2] ^ ror64(s[2],  1) ^ ror64(s[2],  6);
      x_o[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
      x_o[4] = s[4] ^ ror64(s[4],  7) ^ ror64(s[4], 41);
   end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Ascon-p iteration controller: state register, round counter and handshake FSM
// around UNROLL chained asconp rounds. Optional macro ASCON_PERM_ZEROIZE_EN clears
// the state on output handoff.
module ascon_perm_ctrl
   import ascon_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   ascon_perm_ctrl_if.slave  bus
);

   if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
      $error("ascon_perm_ctrl: UNROLL must be 1 or 2");
   end

   perm_state_e              state_q, state_d;
   logic [ROUND_CNT_W-1:0]   cnt_q, cnt_d;
   ascon_state_t             st_q, st_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic                     busy_q, busy_d;

   ascon_state_t             stage_s [UNROLL+1];
   logic [ROUND_CNT_W-1:0]   stage_rc_s [UNROLL];
   logic [ROUND_CNT_W-1:0]   step_s;
   logic [ROUND_CNT_W-1:0]   rounds_sat_s;
   ascon_state_t             in_x_s;

   assign stage_s[0] = st_q;

   for (genvar k = 0; k < UNROLL; k++) begin : g_round
      assign stage_rc_s[k] = cnt_q - ROUND_CNT_W'(k);
      asconp u_round (
         .round_cnt (stage_rc_s[k]),
         .x_i       (stage_s[k]),
         .x_o       (stage_s[k+1])
      );
   end

   assign step_s       = (cnt_q < ROUND_CNT_W'(UNROLL)) ? cnt_q : ROUND_CNT_W'(UNROLL);
   assign rounds_sat_s = (bus.rounds_i > ROUND_CNT_W'(ROUNDS_PA)) ?
                         ROUND_CNT_W'(ROUNDS_PA) : bus.rounds_i;
   assign in_x_s       = {bus.x4_i, bus.x3_i, bus.x2_i, bus.x1_i, bus.x0_i};

   // Next-state, counter, datapath select and registered-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      st_d    = st_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid_i && in_ready_q) begin
               st_d    = in_x_s;
               cnt_d   = rounds_sat_s;
               state_d = (rounds_sat_s != 4'd0) ? RUN : DONE;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            cnt_d = cnt_q - step_s;
            st_d  = (step_s == 4'd1) ? stage_s[1] : stage_s[UNROLL];
            state_d = (cnt_d == 4'd0) ? DONE : RUN;
         end
         DONE: begin
            if (out_valid_q && bus.out_ready_i) begin
               state_d = IDLE;
`ifdef ASCON_PERM_ZEROIZE_EN
               st_d    = '0;
`endif
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d == RUN);
      // A zero-round accept lands in DONE but raises valid one edge later.
      out_valid_d = (state_d == DONE) && (state_q != IDLE);
   end

   // State, counter, permutation state and output flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         st_q        <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         st_q        <= st_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready_o  = in_ready_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.busy_o      = busy_q;
   assign bus.x0_o        = st_q[0];
   assign bus.x1_o        = st_q[1];
   assign bus.x2_o        = st_q[2];
   assign bus.x3_o        = st_q[3];
   assign bus.x4_o        = st_q[4];

endmodule

// File: doc/ascon_perm_ctrl.md
Name: ascon_perm_ctrl

Overview:
Sequential Ascon-p driver that sits directly upstream of the combinational single-round function `asconp`, and owns everything that function lacks.
- Holds the 320-bit state register, generates the per-round `round_cnt`, and iterates a requested number of rounds (6/8/12 typical) at UNROLL rounds per clock.
- Valid/ready handshakes on both sides decouple it from the AEAD/hash mode controller.

Parameters:
UNROLL, 1, rounds applied per clock; legal values 1 or 2 (elaboration error otherwise).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid_i  input  1  input state and round count valid
in_ready_o  output  1  block can accept a new state
rounds_i  input  4  number of rounds to apply (0..12; values >12 saturate to 12)
x0_i..x4_i  input  64 each  input state words
out_valid_o  output  1  permuted state valid
out_ready_i  input  1  consumer accepts output
x0_o..x4_o  output  64 each  state register contents
busy_o  output  1  high in RUN

Behaviour:
- Reset values (asynchronous, rst_n low): FSM=IDLE, in_ready_o=0 while reset is asserted and 1 from the first cycle after release, out_valid_o=0, busy_o=0, round counter=0, state register=0 (so x*_o=0).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&in_ready_o: load x0_i..x4_i into state and cnt=min(rounds_i,12).
  - Go to RUN if cnt≠0, else to DONE (state unchanged).
- RUN:
  - in_ready_o=0, busy_o=1.
  - Each clock applies n=min(UNROLL,cnt) rounds; cnt-=n.
  - Round k of the cycle (k=0..n-1) drives `round_cnt`=cnt-k, so the first round of p12 uses `round_cnt`=12 (constant 0xF0), p8 uses 8 (0xB4) and p6 uses 6 (0x96).
  - When UNROLL=2 and one round remains, only the first stage's output is registered.
  - When the post-update cnt=0, go to DONE.
- DONE:
  - out_valid_o=1, state held stable.
  - On out_ready_i: go to IDLE and drop out_valid_o next cycle.
  - No new input is accepted in the same cycle; there is no IDLE bypass.
- Latency: acceptance edge T; out_valid_o is high from edge T+ceil(nr/UNROLL).
  - nr=0: out_valid_o high from edge T+1 (edge after acceptance), state unchanged.
  - Throughput: one permutation per ceil(nr/UNROLL)+2 cycles minimum.
- in_valid_i while not ready is ignored (no queueing). x*_i need only be stable on the accept cycle.
- out_ready_i outside DONE is ignored.
- x*_o are registered outputs only (no combinational path from inputs). They reflect intermediate state during RUN; the consumer qualifies them with out_valid_o.
- Reset mid-RUN or mid-DONE: immediate abort to reset values; no partial output is flagged valid.

Optional Feature:
ASCON_PERM_ZEROIZE_EN:
- Defined: on the out_valid_o&out_ready_i handshake, the state register is cleared to 0 on the same edge as the return to IDLE (key-material hygiene), so x*_o read 0 in IDLE.
- Undefined: state retained after handoff until the next load.

Decomposition:
- Shared package `ascon_pkg`:
  - state typedef (5 x 64-bit word array).
  - constants ROUNDS_PA=12, ROUNDS_PB=6, ROUNDS_P8=8, ROUND_CNT_W=4.
  - FSM enum {IDLE,RUN,DONE}.
- Sub-modules: UNROLL instances of the team's existing round-function module `asconp`, chained combinationally in a generate loop.
- The controller itself (FSM + counter + state register) stays in this module; no further split.

Test Plan:
1. UNROLL=1, p12 on all-zero state:
   - Accept at edge T → out_valid_o at T+12.
   - Output equals the team's Ascon-p12 software model.
   - `round_cnt` sequence 12..1 observed at the stage-0 input.
2. UNROLL=2, p6 and p8 on a random state:
   - out_valid_o at T+3 and T+4 respectively.
   - Results match the model; first-round constants 0x96 and 0xB4.
3. UNROLL=2, rounds_i=7:
   - out_valid_o at T+4.
   - Result equals model p7 (last cycle single round, `round_cnt` 1).
4. Backpressure:
   - Hold out_ready_i=0 for 5 cycles in DONE; x*_o stable and in_ready_o=0 throughout.
   - in_valid_i pulses are ignored; raising out_ready_i returns to IDLE next edge.
5. Boundaries:
   - rounds_i=0 → out_valid_o at T+1 with output = input.
   - rounds_i=15 → behaves as 12 (T+12 with UNROLL=1).
6. Async reset asserted mid-RUN (after round 5 of p12):
   - Outputs drop to reset values without a clock edge.
   - No out_valid_o after release.
   - With ASCON_PERM_ZEROIZE_EN, state reads 0 after handshake.
